// File: rtl/rom_server.sv
// rom_server: CPU program ROM loaded from the download stream; optional checksum via ROM_SERVER_CHECKSUM_EN
module rom_server #(
    parameter int ADDR_WIDTH   = 12,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [7:0]            rom_data,
    input  logic                  ioctl_download,
    input  logic                  ioctl_wr,
    input  logic [15:0]           ioctl_addr,
    input  logic [7:0]            ioctl_dout,
    output logic                  cpu_reset,
    output logic                  rom_ready,
    output logic [ADDR_WIDTH:0]   load_count,
    output logic [15:0]           checksum
);
    localparam logic [1:0] EMPTY   = 2'd0;
    localparam logic [1:0] LOADING = 2'd1;
    localparam logic [1:0] FLUSH   = 2'd2;
    localparam logic [1:0] READY   = 2'd3;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int FW    = $clog2(FLUSH_CYCLES + 2);
    logic [1:0]    state, state_n;
    logic [FW-1:0] flush_cnt;
    logic [7:0]    mem [DEPTH];
    logic          accept, start;
    assign accept    = state == LOADING && ioctl_wr && {16'd0, ioctl_addr} < 32'(DEPTH);
    assign start     = state != LOADING && state_n == LOADING;
    assign cpu_reset = state != READY;
    assign rom_ready = state == READY;
    // next state; a write in the falling-download cycle counts toward the flush decision
    always_comb begin
        state_n = state;
        case (state)
            EMPTY:   state_n = ioctl_download ? LOADING : EMPTY;
            LOADING: state_n = ioctl_download ? LOADING : (load_count != '0 || accept) ? FLUSH : EMPTY;
            FLUSH:   state_n = ioctl_download ? LOADING : (flush_cnt == FW'(FLUSH_CYCLES)) ? READY : FLUSH;
            default: state_n = ioctl_download ? LOADING : READY;
        endcase
    end
    // state, flush timer and saturating byte counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            flush_cnt  <= '0;
            load_count <= '0;
        end else begin
            state     <= state_n;
            flush_cnt <= (state == FLUSH && state_n == FLUSH) ? flush_cnt + 1'b1 : '0;
            if (start)
                load_count <= '0;
            else if (accept && !(&load_count))
                load_count <= load_count + 1'b1;
        end
    end
`ifdef ROM_SERVER_CHECKSUM_EN
    logic [15:0] sum;
    // running 16-bit sum of accepted bytes, cleared when a download starts
    always_ff @(posedge clk) begin
        if (reset || start)
            sum <= '0;
        else if (accept)
            sum <= sum + 16'(ioctl_dout);
    end
    assign checksum = sum;
`else
    assign checksum = 16'h0000;
`endif
    // download write port; the array deliberately survives reset
    always_ff @(posedge clk) begin
        if (accept)
            mem[ioctl_addr[ADDR_WIDTH-1:0]] <= ioctl_dout;
    end
    // fetch port: enabled reads in READY, zero whenever the CPU is held off
    always_ff @(posedge clk) begin
        if (reset || state_n != READY)
            rom_data <= 8'h00;
        else if (clk_en)
            rom_data <= mem[rom_addr];
    end
endmodule
